// File: rtl/txbuf_formatter.sv
// rtl/txbuf_formatter.sv - expands txbuf display commands into an ASCII byte stream
module txbuf_formatter #(
    parameter logic [7:0] NEWLINE = 8'h0A,
    parameter int         ERR_LEN = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [31:0] cmd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_byte,
    output logic        busy,
    output logic        err_flag
);

    typedef enum logic [2:0] {
        IDLE, LOAD, EMIT_BUF, INT_SIGN, INT_DIV, INT_EMIT, HEX_EMIT, TAIL_NL
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  pow_q, pow_d;
    logic [3:0]  dig_q, dig_d;
    logic        started_q, started_d;
    logic        err_q, err_d;
    logic        hs;

    function automatic logic [31:0] pow10(input logic [3:0] p);
        case (p)
            4'd0:    pow10 = 32'd1000000000;
            4'd1:    pow10 = 32'd100000000;
            4'd2:    pow10 = 32'd10000000;
            4'd3:    pow10 = 32'd1000000;
            4'd4:    pow10 = 32'd100000;
            4'd5:    pow10 = 32'd10000;
            4'd6:    pow10 = 32'd1000;
            4'd7:    pow10 = 32'd100;
            4'd8:    pow10 = 32'd10;
            default: pow10 = 32'd1;
        endcase
    endfunction

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        hex_ascii = (n < 4'd10) ? (8'h30 + {4'b0, n}) : (8'h37 + {4'b0, n});
    endfunction

    assign hs        = out_valid && out_ready;
    assign cmd_ready = (state_q == IDLE);
    assign busy      = ~cmd_ready;
    assign err_flag  = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            pow_q     <= '0;
            dig_q     <= '0;
            started_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            pow_q     <= pow_d;
            dig_q     <= dig_d;
            started_q <= started_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        pow_d     = pow_q;
        dig_d     = dig_q;
        started_d = started_q;
        err_d     = err_q;
        out_valid = 1'b0;
        out_byte  = 8'h00;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    data_d  = cmd_data;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                case (op_q)
                    4'd0: state_d = IDLE;
                    4'd1, 4'd2, 4'd3, 4'd4: begin
                        cnt_d   = op_q;
                        state_d = EMIT_BUF;
                    end
                    4'd5, 4'd6, 4'd7: begin
                        data_d  = {1'b0, data_q[23:17], 1'b0, data_q[16:10],
                                   1'b0, data_q[9:3], 8'h00};
                        cnt_d   = op_q - 4'd4;
                        state_d = EMIT_BUF;
                    end
                    4'd8: begin
                        data_d  = {8'h45, 8'h52, 8'h52, NEWLINE};
                        cnt_d   = 4'(ERR_LEN);
                        state_d = EMIT_BUF;
                    end
                    4'd9, 4'd11: begin
                        // Two's-complement negate gives the right magnitude even for 0x80000000.
                        data_d    = data_q[31] ? (~data_q + 32'd1) : data_q;
                        pow_d     = 4'd0;
                        dig_d     = 4'd0;
                        started_d = 1'b0;
                        state_d   = data_q[31] ? INT_SIGN : INT_DIV;
                    end
                    4'd10, 4'd12: begin
                        cnt_d   = 4'd0;
                        state_d = HEX_EMIT;
                    end
                    default: begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                endcase
            end
            EMIT_BUF: begin
                out_valid = 1'b1;
                out_byte  = data_q[31:24];
                if (hs) begin
                    data_d = {data_q[23:0], 8'h00};
                    cnt_d  = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = IDLE;
                end
            end
            INT_SIGN: begin
                out_valid = 1'b1;
                out_byte  = 8'h2D;
                if (hs) state_d = INT_DIV;
            end
            INT_DIV: begin
                // One restoring subtract per cycle; a leading zero just advances the power.
                if (data_q >= pow10(pow_q)) begin
                    data_d = data_q - pow10(pow_q);
                    dig_d  = dig_q + 4'd1;
                end else if (dig_q != 4'd0 || started_q || pow_q == 4'd9) begin
                    state_d = INT_EMIT;
                end else begin
                    pow_d = pow_q + 4'd1;
                end
            end
            INT_EMIT: begin
                out_valid = 1'b1;
                out_byte  = 8'h30 + {4'b0, dig_q};
                if (hs) begin
                    started_d = 1'b1;
                    dig_d     = 4'd0;
                    if (pow_q == 4'd9) begin
                        state_d = TAIL_NL;
                    end else begin
                        pow_d   = pow_q + 4'd1;
                        state_d = INT_DIV;
                    end
                end
            end
            HEX_EMIT: begin
                out_valid = 1'b1;
                case (cnt_q)
                    4'd0:    out_byte = 8'h30;
                    4'd1:    out_byte = 8'h78;
                    default: out_byte = hex_ascii(data_q[31:28]);
                endcase
                if (hs) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q >= 4'd2) data_d = {data_q[27:0], 4'h0};
                    if (cnt_q == 4'd9) state_d = TAIL_NL;
                end
            end
            TAIL_NL: begin
                out_valid = 1'b1;
                out_byte  = NEWLINE;
                if (hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
